// File: rtl/fetch_unit.sv
// Instruction fetch stage around the program counter register.
// One outstanding imem read, falling-edge state, redirect-aware flush.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    localparam logic [XLEN-1:0] STEP     = XLEN'(4);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);

    state_t          state_q;
    state_t          state_d;
    logic            capture;
    logic [XLEN-1:0] redir_pc;

    assign redir_pc      = redirect_target & ~LOW_MASK;
    assign imem_req_addr = pc_cur;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            inst_data <= '0;
            inst_pc   <= '0;
        end else if (capture) begin
            inst_data <= imem_resp_data;
            inst_pc   <= pc_cur;
        end
    end

    // Redirect wins over every other event once the stage has booted.
    always_comb begin
        state_d        = state_q;
        pc_next        = pc_cur;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        capture        = 1'b0;
        unique case (state_q)
            BOOT: begin
                pc_next = RESET_VECTOR;
                state_d = REQ;
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (redirect_valid) begin
                    pc_next = redir_pc;
                    state_d = imem_req_ready ? DROP : REQ;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_next = redir_pc;
                    state_d = imem_resp_valid ? REQ : DROP;
                end else if (imem_resp_valid) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                inst_valid = ~redirect_valid;
                if (redirect_valid) begin
                    pc_next = redir_pc;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_next = pc_cur + STEP;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_next = redir_pc;
                end
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed plan steps then random traffic,
// checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0100;

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic [31:0] pc_cur = '0;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;

    // Model: what the stage owes the outside world.
    bit          booted;
    bit          need_req;
    bit          pending;
    bit          discard;
    bit          held;
    logic [31:0] m_data;
    logic [31:0] m_pc;

    // Memory: single outstanding read with programmable latency.
    bit          mem_pend;
    int          mem_dly;
    logic [31:0] mem_data;
    bit          poison;

    fetch_unit #(
        .XLEN(XLEN),
        .RESET_VECTOR(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_cur(pc_cur),
        .pc_next(pc_next),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        booted   = 0;
        need_req = 0;
        pending  = 0;
        discard  = 0;
        held     = 0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] tgt,
                        input bit irdy, input int dly);
        logic        e_req;
        logic        e_iv;
        logic [31:0] e_pc;
        bit          acc;
        imem_req_ready  = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        inst_ready      = irdy;
        imem_resp_valid = mem_pend && (mem_dly == 0);
        imem_resp_data  = mem_pend ? mem_data : 32'h0;
        e_req = booted && need_req;
        e_iv  = booted && held && !rv;
        if (!booted) e_pc = RV;
        else if (rv) e_pc = {tgt[31:2], 2'b00};
        else if (held && irdy) e_pc = pc_cur + 32'd4;
        else e_pc = pc_cur;
        #2;
        chk("pc_next", pc_next, e_pc);
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
        if (e_req) chk("req_addr", imem_req_addr, pc_cur);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
        if (e_iv) begin
            chk("inst_data", inst_data, m_data);
            chk("inst_pc", inst_pc, m_pc);
        end
        @(negedge clk);
        #1;
        acc = e_req && rdy;
        if (!booted) begin
            booted   = 1;
            need_req = 1;
        end else if (need_req) begin
            if (rdy) begin
                need_req = 0;
                pending  = 1;
                discard  = rv;
            end
        end else if (pending) begin
            if (imem_resp_valid) begin
                pending = 0;
                if (discard || rv) begin
                    need_req = 1;
                end else begin
                    held   = 1;
                    m_data = imem_resp_data;
                    m_pc   = pc_cur;
                end
            end else if (rv) begin
                discard = 1;
            end
        end else if (held) begin
            if (rv || irdy) begin
                held     = 0;
                need_req = 1;
            end
        end
        if (imem_resp_valid) mem_pend = 0;
        else if (mem_pend && mem_dly > 0) mem_dly--;
        if (acc) begin
            mem_pend = 1;
            mem_dly  = dly;
            mem_data = poison ? 32'hDEAD_BEEF : mem_word(pc_cur);
            poison   = 0;
        end
        pc_cur = e_pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        mem_pend = 0;
        mem_dly  = 0;
        mem_data = '0;
        poison   = 0;
        m_data   = '0;
        m_pc     = '0;

        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_pc_next", pc_next, RV);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        reset = 1'b1;

        step(0, 0, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        repeat (4) step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 0);

        poison = 1;
        step(1, 0, 32'h0, 0, 1);
        step(0, 1, 32'h203, 0, 0);
        step(0, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 1, 32'h40, 1, 0);

        step(0, 1, 32'hFFFF_FFFF, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 0);

        step(1, 0, 32'h0, 0, 1);
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b0;
        inst_ready      = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("midrst_pc_next", pc_next, RV);
        chk("midrst_inst_valid", {31'b0, inst_valid}, 32'h0);
        model_clear();
        @(negedge clk);
        #1;
        if (mem_pend && mem_dly > 0) mem_dly--;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0),
                 $urandom,
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly around the ProgramCounter register. It consumes the PC's current value and produces the PC's next value every cycle.
- It issues one instruction-memory read per PC with a valid/ready handshake and holds the returned word for decode.
- It handles control-flow redirects, including flushing a response that is still in flight.
- All sequential state updates on the falling edge of clk, matching ProgramCounter.

Parameters:
XLEN, 32, datapath and address width
RESET_VECTOR, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock; state updates on falling edge
reset  in  1  asynchronous, active-low; low clears all state immediately
pc_cur  in  XLEN  current PC (ProgramCounter pc_out)
pc_next  out  XLEN  next PC (ProgramCounter pc_in), combinational
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  read address, equals pc_cur
imem_resp_valid  in  1  read data valid (one-cycle pulse per accepted request)
imem_resp_data  in  32  read data
redirect_valid  in  1  branch/jump taken
redirect_target  in  XLEN  redirect address
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_data  out  32  held instruction
inst_pc  out  XLEN  address of held instruction

Behaviour:
- FSM states: BOOT, REQ, WAIT, HOLD, DROP. Reset value is BOOT.
- inst_data and inst_pc reset to 0.
- At most one request is outstanding at any time.
- BOOT:
  - imem_req_valid=0, inst_valid=0, pc_next=RESET_VECTOR.
  - First falling edge with reset high -> REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_cur, pc_next=pc_cur.
  - Edge with imem_req_ready=1 -> WAIT.
- WAIT:
  - imem_req_valid=0, pc_next=pc_cur.
  - Edge with imem_resp_valid=1: inst_data<=imem_resp_data, inst_pc<=pc_cur, -> HOLD.
- HOLD:
  - inst_valid=1 (gated low if redirect_valid=1), pc_next=pc_cur.
  - When inst_valid && inst_ready: pc_next=pc_cur+4, edge -> REQ.
- DROP:
  - imem_req_valid=0, inst_valid=0, pc_next=pc_cur.
  - Edge with imem_resp_valid=1: data discarded, -> REQ.
- Redirect:
  - Has priority over every other event in REQ/WAIT/HOLD/DROP.
  - pc_next={redirect_target[XLEN-1:2],2'b00}; misaligned low bits are silently cleared.
  - Next-state on redirect:
    - REQ with ready=0 -> REQ.
    - REQ with ready=1 -> DROP.
    - WAIT with resp_valid=0 -> DROP.
    - WAIT with resp_valid=1 -> REQ (response discarded).
    - HOLD -> REQ (held instruction discarded, never handed off).
    - DROP with resp_valid=1 -> REQ.
    - DROP with resp_valid=0 -> DROP.
  - Redirect in BOOT is ignored.
- Arithmetic: pc_cur+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Reset asserted mid-operation:
  - State -> BOOT immediately, not waiting for a clock edge.
  - Outputs take BOOT values combinationally.
  - Any outstanding response arriving after release is ignored; it only advances a state in WAIT/DROP, which BOOT is not.
- Throughput: minimum 3 falling edges per instruction (REQ->WAIT->HOLD->REQ) with zero-wait memory and decode.

Test Plan:
- Reset/boot: reset=0 for 2 edges, RESET_VECTOR=32'h100 -> pc_next=32'h100, imem_req_valid=0, inst_valid=0. Release reset -> after 1 edge PC=32'h100; next cycle imem_req_valid=1, imem_req_addr=32'h100.
- Straight-line fetch: ready=1, resp_valid one cycle after accept with data 32'h00500093, inst_ready=1 -> inst_valid=1, inst_data=32'h00500093, inst_pc=32'h100. pc_next=32'h104 in HOLD; next request addr=32'h104.
- Decode stall: HOLD with inst_ready=0 for 4 edges -> inst_valid stays 1, data/pc stable, pc_next=pc_cur, no new request. inst_ready=1 -> advance to 32'h104.
- Redirect in flight: in WAIT, redirect_valid=1, target=32'h203 -> pc_next=32'h200, state DROP. Response 32'hDEADBEEF arrives -> inst_valid never asserts. Next request addr=32'h200.
- Redirect vs handoff: HOLD, inst_ready=1 and redirect_valid=1 (target 32'h40) on the same cycle -> inst_valid=0, pc_next=32'h40, state REQ.
- Wrap and mid-op reset: pc_cur=32'hFFFF_FFFC, handoff -> pc_next=32'h0. Separately, assert reset in WAIT between edges -> imem_req_valid=0 and pc_next=RESET_VECTOR immediately. A late resp_valid after release is ignored.
